// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding,
// transaction owner and default bus widths.
package mem_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 36;
  localparam int unsigned INSTR_WIDTH_DEF = 18;
  localparam int unsigned ADDR_WIDTH_DEF  = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned INSTRUCTION_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned ADDRESS_BUS_WIDTH = ADDR_WIDTH_DEF
);
  logic                         i_if_req;
  logic [ADDRESS_BUS_WIDTH-1:0] i_if_addr;
  logic                         o_if_valid;
  logic [INSTRUCTION_WIDTH-1:0] o_if_instr;
  logic                         o_if_stall;

  logic                         i_d_read;
  logic                         i_d_write;
  logic [ADDRESS_BUS_WIDTH-1:0] i_d_addr;
  logic [DATA_WIDTH-1:0]        i_d_wdata;
  logic                         o_d_valid;
  logic [DATA_WIDTH-1:0]        o_d_rdata;
  logic                         o_d_stall;

  logic                         o_mem_req;
  logic                         o_mem_we;
  logic [ADDRESS_BUS_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0]        o_mem_wdata;
  logic                         i_mem_ack;
  logic [DATA_WIDTH-1:0]        i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_d_read, i_d_write, i_d_addr, i_d_wdata,
           i_mem_ack, i_mem_rdata,
    output o_if_valid, o_if_instr, o_if_stall, o_d_valid, o_d_rdata, o_d_stall,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_d_read, i_d_write, i_d_addr, i_d_wdata,
           i_mem_ack, i_mem_rdata,
    input  o_if_valid, o_if_instr, o_if_stall, o_d_valid, o_d_rdata, o_d_stall,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Grant decision: data wins unless a fetch is waiting and the data burst
// limit has been reached.
module arb_pick #(
  parameter int unsigned D_BURST_MAX = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             if_pending,
  input  logic             d_pending,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             grant_if,
  output logic             grant_d
);

  logic burst_full;

  always_comb begin
    burst_full = (burst_cnt == CNT_W'(D_BURST_MAX));
    grant_d    = d_pending & ~(if_pending & burst_full);
    grant_if   = if_pending & ~grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// with registered memory request outputs and a data burst limit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned INSTRUCTION_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned ADDRESS_BUS_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned D_BURST_MAX       = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(D_BURST_MAX + 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             burst_q, burst_d;
  logic                         mem_req_q, mem_req_d;
  logic                         mem_we_q, mem_we_d;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]        mem_wdata_q, mem_wdata_d;

  logic   if_pending, d_pending, grant_if, grant_d, mem_ack;
  logic   if_valid, d_valid;
  owner_e owner;

  assign if_pending = bus.i_if_req;
  assign d_pending  = bus.i_d_read | bus.i_d_write;
  assign mem_ack    = bus.i_mem_ack & mem_req_q;

  arb_pick #(
    .D_BURST_MAX (D_BURST_MAX),
    .CNT_W       (CNT_W)
  ) u_arb_pick (
    .if_pending (if_pending),
    .d_pending  (d_pending),
    .burst_cnt  (burst_q),
    .grant_if   (grant_if),
    .grant_d    (grant_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Burst count only matters while a fetch waits; any idle-fetch edge clears it.
  always_comb begin
    state_d     = state_q;
    burst_d     = if_pending ? burst_q : '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.i_d_write;
          mem_addr_d  = bus.i_d_addr;
          mem_wdata_d = bus.i_d_wdata;
          if (if_pending && burst_q != CNT_W'(D_BURST_MAX)) begin
            burst_d = burst_q + CNT_W'(1);
          end
        end else if (grant_if) begin
          state_d    = IF_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.i_if_addr;
          burst_d    = '0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Completion is suppressed during reset so an abandoned access never reports.
  always_comb begin
    owner    = (state_q == IF_BUSY) ? OWN_IF : OWN_D;
    if_valid = mem_ack & ~i_rst & (owner == OWN_IF);
    d_valid  = mem_ack & ~i_rst & (owner == OWN_D);
  end

  assign bus.o_if_valid  = if_valid;
  assign bus.o_if_instr  = bus.i_mem_rdata[INSTRUCTION_WIDTH-1:0];
  assign bus.o_if_stall  = if_pending & ~if_valid;
  assign bus.o_d_valid   = d_valid;
  assign bus.o_d_rdata   = bus.i_mem_rdata;
  assign bus.o_d_stall   = d_pending & ~d_valid;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule
